alu_mc: RTL and testbench

- Parametrised, handshaked, multi-cycle successor to the combinational execute ALU.
- Keeps the ALUOp/funct3/funct7 decode: load/store add, branch subtract, R/I arithmetic.
- Extends the decode to the full RV32I ALU set.
- Adds iterative RV M-extension multiply and divide/remainder.
- Sits in the EX stage. Stalls the pipeline through in_ready/out_valid while a long operation runs.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_muldiv_iter.sv | 103 ++++++++++
 rtl/alu_mc.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_mc.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle execute ALU: ALUOp, funct3/funct7
// decode constants, the control state enum and an M-extension sign helper.
package alu_pkg;

    // ALUOp encodings driven by the main decoder
    localparam logic [1:0] ALU_LS  = 2'b00;   // load/store address: add
    localparam logic [1:0] ALU_BR  = 2'b01;   // branch compare: subtract
    localparam logic [1:0] ALU_R   = 2'b10;   // decode by funct3/funct7
    localparam logic [1:0] ALU_RSV = 2'b11;   // reserved: result 0

    // Base integer funct3 encodings
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SRL  = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    // M-extension funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam int         FUNCT7_ALT    = 5;   // sub / sra select bit

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_e;

    // Operand signedness for an M op: {a_signed, b_signed}
    function automatic logic [1:0] md_signed(input logic [2:0] f3);
        logic [1:0] sgn;
        case (f3)
            F3_MUL, F3_MULH: sgn = 2'b11;
            F3_MULHSU:       sgn = 2'b10;
            F3_DIV, F3_REM:  sgn = 2'b11;
            default:         sgn = 2'b00;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Shared iterative engine: XLEN steps of shift-add multiply or restoring
// division on unsigned magnitudes. Results are presented from the next-state
// value so the caller can capture them on the edge of the final step.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              done_o,
    output logic [2*XLEN-1:0] product_o,
    output logic [XLEN-1:0]   quotient_o,
    output logic [XLEN-1:0]   remainder_o
);

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic            run_q, run_d;
    logic            div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] hi_q, hi_d;    // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;    // multiplier bits / dividend->quotient
    logic [XLEN-1:0] b_q, b_d;      // multiplicand / divisor
    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_shift_s;
    logic [XLEN:0]   div_diff_s;
    logic            last_s;

    // One multiply or divide step per cycle while running
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_q, lo_q[XLEN-1]};
        div_diff_s  = div_shift_s - {1'b0, b_q};
        last_s      = (cnt_q == LAST);
        run_d = run_q;
        div_d = div_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        if (start_i) begin
            run_d = 1'b1;
            div_d = is_div_i;
            cnt_d = {CW{1'b0}};
            hi_d  = {XLEN{1'b0}};
            lo_d  = a_i;
            b_d   = b_i;
        end else if (run_q) begin
            if (last_s) begin
                run_d = 1'b0;
                cnt_d = {CW{1'b0}};
            end else begin
                run_d = 1'b1;
                cnt_d = cnt_q + CW'(1);
            end
            if (div_q) begin
                // Restore (keep the shifted value) when the trial subtract borrows
                if (!div_diff_s[XLEN]) begin
                    hi_d = div_diff_s[XLEN-1:0];
                end else begin
                    hi_d = div_shift_s[XLEN-1:0];
                end
                lo_d = {lo_q[XLEN-2:0], ~div_diff_s[XLEN]};
            end else begin
                hi_d = mul_sum_s[XLEN:1];
                lo_d = {mul_sum_s[0], lo_q[XLEN-1:1]};
            end
        end else begin
            run_d = 1'b0;
        end
    end

    // Engine state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_q <= 1'b0;
            div_q <= 1'b0;
            cnt_q <= {CW{1'b0}};
            hi_q  <= {XLEN{1'b0}};
            lo_q  <= {XLEN{1'b0}};
            b_q   <= {XLEN{1'b0}};
        end else begin
            run_q <= run_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
        end
    end

    assign done_o      = run_q & last_s;
    assign product_o   = {hi_d, lo_d};
    assign quotient_o  = lo_d;
    assign remainder_o = hi_d;

endmodule

// File: rtl/alu_mc.sv
// Handshaked multi-cycle execute ALU: RV32I ALU set in one cycle, M-extension
// multiply/divide on a shared iterative engine. Result and zero flag are
// registered and held until the consumer takes them.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1,
    parameter bit DIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_q, neg_d;      // product / quotient negate
    logic              rneg_q, rneg_d;    // remainder negate
    logic              bzero_q, bzero_d;  // divide by zero

    logic [XLEN-1:0]   b_sel_s;
    logic [SHW-1:0]    shamt_s;
    logic [XLEN-1:0]   fast_res_s;
    logic [1:0]        md_sgn_s;
    logic              a_neg_s, b_neg_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic              accept_s, is_m_s, is_mul_s, is_div_s, eng_start_s;
    logic              eng_done_s;
    logic [2*XLEN-1:0] eng_product_s;
    logic [XLEN-1:0]   eng_quotient_s, eng_remainder_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   mul_res_s, quo_fix_s, rem_fix_s, div_res_s;

    // Operand select, op classification and magnitudes for the engine
    always_comb begin
        b_sel_s     = alu_src ? imm : read_data2;
        accept_s    = in_valid & (state_q == IDLE);
        is_m_s      = (alu_op == ALU_R) & ~alu_src & (funct7 == FUNCT7_MULDIV);
        is_mul_s    = is_m_s & ~funct3[2];
        is_div_s    = is_m_s & funct3[2];
        eng_start_s = accept_s & ((is_mul_s & MUL_EN) | (is_div_s & DIV_EN));
        md_sgn_s    = md_signed(funct3);
        a_neg_s     = md_sgn_s[1] & read_data1[XLEN-1];
        b_neg_s     = md_sgn_s[0] & b_sel_s[XLEN-1];
        a_mag_s     = a_neg_s ? -read_data1 : read_data1;
        b_mag_s     = b_neg_s ? -b_sel_s : b_sel_s;
    end

    // Single-cycle result for the base integer operations
    always_comb begin
        shamt_s    = b_sel_s[SHW-1:0];
        fast_res_s = {XLEN{1'b0}};
        case (alu_op)
            ALU_LS: fast_res_s = read_data1 + b_sel_s;
            ALU_BR: fast_res_s = read_data1 - b_sel_s;
            ALU_R: begin
                if (!funct7[0] || alu_src) begin
                    case (funct3)
                        F3_ADD: begin
                            if (funct7[FUNCT7_ALT] && !alu_src) begin
                                fast_res_s = read_data1 - b_sel_s;
                            end else begin
                                fast_res_s = read_data1 + b_sel_s;
                            end
                        end
                        F3_SLL:  fast_res_s = read_data1 << shamt_s;
                        F3_SLT:  fast_res_s = {{(XLEN-1){1'b0}}, ($signed(read_data1) < $signed(b_sel_s))};
                        F3_SLTU: fast_res_s = {{(XLEN-1){1'b0}}, (read_data1 < b_sel_s)};
                        F3_XOR:  fast_res_s = read_data1 ^ b_sel_s;
                        F3_SRL: begin
                            if (funct7[FUNCT7_ALT]) begin
                                fast_res_s = $signed(read_data1) >>> shamt_s;
                            end else begin
                                fast_res_s = read_data1 >> shamt_s;
                            end
                        end
                        F3_OR:   fast_res_s = read_data1 | b_sel_s;
                        F3_AND:  fast_res_s = read_data1 & b_sel_s;
                        default: fast_res_s = {XLEN{1'b0}};
                    endcase
                end else begin
                    // M ops land here only when their engine is not built
                    fast_res_s = {XLEN{1'b0}};
                end
            end
            default: fast_res_s = {XLEN{1'b0}};
        endcase
    end

    generate
        if (MUL_EN || DIV_EN) begin : g_engine
            alu_muldiv_iter #(
                .XLEN(XLEN)
            ) u_iter (
                .clk        (clk),
                .rst_n      (rst_n),
                .start_i    (eng_start_s),
                .is_div_i   (is_div_s),
                .a_i        (a_mag_s),
                .b_i        (b_mag_s),
                .done_o     (eng_done_s),
                .product_o  (eng_product_s),
                .quotient_o (eng_quotient_s),
                .remainder_o(eng_remainder_s)
            );
        end else begin : g_no_engine
            assign eng_done_s      = 1'b0;
            assign eng_product_s   = {(2*XLEN){1'b0}};
            assign eng_quotient_s  = {XLEN{1'b0}};
            assign eng_remainder_s = {XLEN{1'b0}};
        end
    endgenerate

    // Sign fix-up of engine results; divide-by-zero quotient forced to all ones
    always_comb begin
        prod_fix_s = neg_q ? -eng_product_s : eng_product_s;
        mul_res_s  = (f3_q == F3_MUL) ? prod_fix_s[XLEN-1:0] : prod_fix_s[2*XLEN-1:XLEN];
        if (bzero_q) begin
            quo_fix_s = {XLEN{1'b1}};
        end else begin
            quo_fix_s = neg_q ? -eng_quotient_s : eng_quotient_s;
        end
        rem_fix_s = rneg_q ? -eng_remainder_s : eng_remainder_s;
        div_res_s = f3_q[1] ? rem_fix_s : quo_fix_s;
    end

    // Control FSM next state and result register updates
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        f3_d     = f3_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        bzero_d  = bzero_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    f3_d    = funct3;
                    neg_d   = a_neg_s ^ b_neg_s;
                    rneg_d  = a_neg_s;
                    bzero_d = (b_sel_s == {XLEN{1'b0}});
                    if (is_mul_s && MUL_EN) begin
                        state_d = MUL;
                    end else if (is_div_s && DIV_EN) begin
                        state_d = DIV;
                    end else begin
                        state_d  = DONE;
                        result_d = fast_res_s;
                        zero_d   = (fast_res_s == {XLEN{1'b0}});
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                if (eng_done_s) begin
                    state_d  = DONE;
                    result_d = mul_res_s;
                    zero_d   = (mul_res_s == {XLEN{1'b0}});
                end else begin
                    state_d = MUL;
                end
            end
            DIV: begin
                if (eng_done_s) begin
                    state_d  = DONE;
                    result_d = div_res_s;
                    zero_d   = (div_res_s == {XLEN{1'b0}});
                end else begin
                    state_d = DIV;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= {XLEN{1'b0}};
            zero_q   <= 1'b1;
            f3_q     <= 3'd0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            bzero_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            bzero_q  <= bzero_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign busy       = (state_q == MUL) || (state_q == DIV);
    assign alu_result = result_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 32-bit full build and a 16-bit build without
// the multiplier, sharing clock and reset.
module tb_alu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid_a, in_ready_a, alu_src_a, out_valid_a, out_ready_a, zero_a, busy_a;
    logic [31:0] rd1_a, rd2_a, imm_a, res_a;
    logic [1:0]  op_a;
    logic [2:0]  f3_a;
    logic [6:0]  f7_a;

    logic        in_valid_b, in_ready_b, alu_src_b, out_valid_b, out_ready_b, zero_b, busy_b;
    logic [15:0] rd1_b, rd2_b, imm_b, res_b;
    logic [1:0]  op_b;
    logic [2:0]  f3_b;
    logic [6:0]  f7_b;

    int errors = 0;
    int checks = 0;

    alu_mc #(.XLEN(32), .MUL_EN(1'b1), .DIV_EN(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .read_data1(rd1_a), .read_data2(rd2_a), .imm(imm_a), .alu_src(alu_src_a),
        .alu_op(op_a), .funct3(f3_a), .funct7(f7_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .alu_result(res_a), .zero(zero_a), .busy(busy_a)
    );

    alu_mc #(.XLEN(16), .MUL_EN(1'b0), .DIV_EN(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .read_data1(rd1_b), .read_data2(rd2_b), .imm(imm_b), .alu_src(alu_src_b),
        .alu_op(op_b), .funct3(f3_b), .funct7(f7_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .alu_result(res_b), .zero(zero_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait (bounded) for out_valid, capture, then let the handoff edge pass
    task automatic run_op(input bit sel, input logic [1:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic src, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] im,
                          output logic [31:0] res, output logic z, output int lat);
        @(negedge clk);
        if (sel == 1'b0) begin
            in_valid_a = 1'b1; op_a = op; f3_a = f3; f7_a = f7; alu_src_a = src;
            rd1_a = a; rd2_a = b; imm_a = im;
        end else begin
            in_valid_b = 1'b1; op_b = op; f3_b = f3; f7_b = f7; alu_src_b = src;
            rd1_b = a[15:0]; rd2_b = b[15:0]; imm_b = im[15:0];
        end
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        lat = 1;
        while (((sel == 1'b0) ? !out_valid_a : !out_valid_b) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = (sel == 1'b0) ? res_a : {16'h0000, res_b};
        z   = (sel == 1'b0) ? zero_a : zero_b;
        @(posedge clk);
        #1;
    endtask

    task automatic op_chk(input string tag, input bit sel, input logic [1:0] op,
                          input logic [2:0] f3, input logic [6:0] f7, input logic src,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                          input logic [31:0] exp_res, input logic exp_z, input int exp_lat);
        logic [31:0] res;
        logic        z;
        int          lat;
        run_op(sel, op, f3, f7, src, a, b, im, res, z, lat);
        chk({tag, "/result"}, res, exp_res);
        chk({tag, "/zero"}, z, exp_z);
        chk({tag, "/latency"}, lat, exp_lat);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid_a = 1'b0; out_ready_a = 1'b1; alu_src_a = 1'b0; op_a = 2'b00;
        f3_a = 3'd0; f7_a = 7'd0; rd1_a = 32'd0; rd2_a = 32'd0; imm_a = 32'd0;
        in_valid_b = 1'b0; out_ready_b = 1'b1; alu_src_b = 1'b0; op_b = 2'b00;
        f3_b = 3'd0; f7_b = 7'd0; rd1_b = 16'd0; rd2_b = 16'd0; imm_b = 16'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst/out_valid", out_valid_a, 1'b0);
        chk("rst/result", res_a, 32'h0);
        chk("rst/zero", zero_a, 1'b1);
        chk("rst/in_ready", in_ready_a, 1'b1);
        chk("rst/busy", busy_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle base operations
        op_chk("sub_r",   1'b0, 2'b10, 3'd0, 7'h20, 1'b0, 32'd5, 32'd7, 32'd0, 32'hFFFF_FFFE, 1'b0, 1);
        op_chk("br_eq",   1'b0, 2'b01, 3'd0, 7'h00, 1'b0, 32'd9, 32'd9, 32'd0, 32'h0, 1'b1, 1);
        op_chk("srai",    1'b0, 2'b10, 3'd5, 7'h20, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'hF800_0000, 1'b0, 1);
        op_chk("srl",     1'b0, 2'b10, 3'd5, 7'h00, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'h0800_0000, 1'b0, 1);
        op_chk("addi_ls", 1'b0, 2'b00, 3'd0, 7'h00, 1'b1, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd99, 1'b0, 1);
        op_chk("addi_f7", 1'b0, 2'b10, 3'd0, 7'h01, 1'b1, 32'd10, 32'd0, 32'd5, 32'd15, 1'b0, 1);
        op_chk("slt",     1'b0, 2'b10, 3'd2, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b0, 1);
        op_chk("sltu",    1'b0, 2'b10, 3'd3, 7'h00, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1);
        op_chk("sll",     1'b0, 2'b10, 3'd1, 7'h00, 1'b0, 32'd1, 32'h3F, 32'd0, 32'h8000_0000, 1'b0, 1);
        op_chk("xor",     1'b0, 2'b10, 3'd4, 7'h00, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'h0FF0, 1'b0, 1);
        op_chk("rsv",     1'b0, 2'b11, 3'd0, 7'h00, 1'b0, 32'd5, 32'd7, 32'd0, 32'h0, 1'b1, 1);

        // Multiply: XLEN+1 cycle latency
        op_chk("mulh",    1'b0, 2'b10, 3'd1, 7'h01, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
        op_chk("mul",     1'b0, 2'b10, 3'd0, 7'h01, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33);
        op_chk("mulhu",   1'b0, 2'b10, 3'd3, 7'h01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFE, 1'b0, 33);
        op_chk("mulhsu",  1'b0, 2'b10, 3'd2, 7'h01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);

        // Divide corners
        op_chk("div_by0", 1'b0, 2'b10, 3'd4, 7'h01, 1'b0, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
        op_chk("rem_by0", 1'b0, 2'b10, 3'd6, 7'h01, 1'b0, 32'd7, 32'd0, 32'd0, 32'd7, 1'b0, 33);
        op_chk("div_ovf", 1'b0, 2'b10, 3'd4, 7'h01, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
        op_chk("rem_ovf", 1'b0, 2'b10, 3'd6, 7'h01, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h0, 1'b1, 33);
        op_chk("div_neg", 1'b0, 2'b10, 3'd4, 7'h01, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFD, 1'b0, 33);
        op_chk("rem_neg", 1'b0, 2'b10, 3'd6, 7'h01, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
        op_chk("divu",    1'b0, 2'b10, 3'd5, 7'h01, 1'b0, 32'd100, 32'd7, 32'd0, 32'd14, 1'b0, 33);
        op_chk("remu",    1'b0, 2'b10, 3'd7, 7'h01, 1'b0, 32'd100, 32'd7, 32'd0, 32'd2, 1'b0, 33);

        // Back-pressure: result held, new requests ignored, in_ready after handoff
        @(negedge clk);
        out_ready_a = 1'b0;
        in_valid_a = 1'b1; op_a = 2'b00; f3_a = 3'd0; f7_a = 7'h00; alu_src_a = 1'b0;
        rd1_a = 32'h1234; rd2_a = 32'h1;
        @(posedge clk);
        #1;
        rd1_a = 32'hFFFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold/out_valid", out_valid_a, 1'b1);
            chk("hold/result", res_a, 32'h1235);
            chk("hold/zero", zero_a, 1'b0);
            chk("hold/in_ready", in_ready_a, 1'b0);
        end
        @(negedge clk);
        out_ready_a = 1'b1;
        @(posedge clk);
        #1;
        chk("release/in_ready", in_ready_a, 1'b1);
        chk("release/out_valid", out_valid_a, 1'b0);
        chk("release/result", res_a, 32'h1235);
        @(negedge clk);
        in_valid_a = 1'b0;

        // 16-bit build without multiplier
        op_chk("b_mul",  1'b1, 2'b10, 3'd0, 7'h01, 1'b0, 32'd6, 32'd7, 32'd0, 32'h0, 1'b1, 1);
        op_chk("b_divu", 1'b1, 2'b10, 3'd5, 7'h01, 1'b0, 32'd100, 32'd7, 32'd0, 32'd14, 1'b0, 17);
        op_chk("b_div",  1'b1, 2'b10, 3'd4, 7'h01, 1'b0, 32'h0000_FFF9, 32'd2, 32'd0, 32'h0000_FFFD, 1'b0, 17);

        // Reset asserted in the middle of a divide discards it
        @(negedge clk);
        in_valid_a = 1'b1; op_a = 2'b10; f3_a = 3'd5; f7_a = 7'h01; alu_src_a = 1'b0;
        rd1_a = 32'd100; rd2_a = 32'd7;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("middiv/busy", busy_a, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("middiv_rst/out_valid", out_valid_a, 1'b0);
        chk("middiv_rst/result", res_a, 32'h0);
        chk("middiv_rst/zero", zero_a, 1'b1);
        chk("middiv_rst/in_ready", in_ready_a, 1'b1);
        chk("middiv_rst/busy", busy_a, 1'b0);
        chk("rst_b/result", res_b, 16'h0);
        chk("rst_b/zero", zero_b, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("middiv_after/out_valid", out_valid_a, 1'b0);
        chk("middiv_after/result", res_a, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
